// File: rtl/barrel_shifter_feeder_if.sv
// Signal bundle between PE lanes, the feeder and the downstream barrel_shifter.
// master drives lane words, configuration and out_ready; slave is the feeder.
interface barrel_shifter_feeder_if #(
    parameter int WORD_SIZE        = 256,
    parameter int NOF_PES          = 16,
    parameter int NOF_LEVELS       = $clog2(NOF_PES),
    parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
);
    logic [NOF_PES-1:0]           pe_valid;
    logic [NOF_PES-1:0]           pe_ready;
    logic [WORD_SIZE*NOF_PES-1:0] pe_data;
    logic [NOF_LEVELS-1:0]        cfg_shift;
    logic [GROUP_SIZE_WIDTH-1:0]  cfg_group_size;
    logic                         out_valid;
    logic                         out_ready;
    logic [WORD_SIZE*NOF_PES-1:0] out_data;
    logic [NOF_LEVELS-1:0]        out_shift;
    logic [GROUP_SIZE_WIDTH-1:0]  out_group_size;
    logic                         out_partial;

    modport master (
        output pe_valid, pe_data, cfg_shift, cfg_group_size, out_ready,
        input  pe_ready, out_valid, out_data, out_shift, out_group_size, out_partial
    );

    modport slave (
        input  pe_valid, pe_data, cfg_shift, cfg_group_size, out_ready,
        output pe_ready, out_valid, out_data, out_shift, out_group_size, out_partial
    );
endinterface

// File: rtl/barrel_shifter_feeder.sv
// Collects one word per PE lane into a vector for barrel_shifter, with a separate output register.
// Optional collection timeout is built when BSF_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no lane filled; pe_ready follows the live cfg_group_size mask
// COLLECT | some group lanes filled; cfg latched, waiting for the rest
// FULL    | vector complete (or timed out); waiting for the output register
module barrel_shifter_feeder #(
    parameter int WORD_SIZE        = 256,
    parameter int NOF_PES          = 16,
    parameter int NOF_LEVELS       = $clog2(NOF_PES),
    parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input logic                    clk,
    input logic                    rst_n,
    barrel_shifter_feeder_if.slave bus
);
    localparam int GSW = GROUP_SIZE_WIDTH;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t                       state, state_nxt;
    logic [NOF_PES-1:0]           filled;
    logic [WORD_SIZE*NOF_PES-1:0] vec;
    logic [NOF_LEVELS-1:0]        shift_q;
    logic [GSW-1:0]               group_q;
    logic                         out_valid_q;
    logic [WORD_SIZE*NOF_PES-1:0] out_data_q;
    logic [NOF_LEVELS-1:0]        out_shift_q;
    logic [GSW-1:0]               out_group_q;
    logic [NOF_PES-1:0]           mask_live, mask_q, ready_c, accept;
    logic                         start, complete, transfer, timeout_hit;

    // Illegal sizes (0, non-power-of-two, too large) select every lane.
    function automatic logic [NOF_PES-1:0] group_mask(input logic [GSW-1:0] gs);
        logic [GSW-1:0]     eff;
        logic [NOF_PES-1:0] m;
        if (gs == '0 || (gs & (gs - GSW'(1))) != '0 || gs > GSW'(NOF_PES))
            eff = GSW'(NOF_PES);
        else
            eff = gs;
        m = '0;
        for (int i = 0; i < NOF_PES; i++)
            m[i] = (GSW'(i) < eff);
        return m;
    endfunction

    assign mask_live = group_mask(bus.cfg_group_size);
    assign mask_q    = group_mask(group_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_c   = '0;
        accept    = '0;
        start     = 1'b0;
        complete  = 1'b0;
        transfer  = 1'b0;
        case (state)
            IDLE: begin
                ready_c = mask_live;
                accept  = bus.pe_valid & ready_c;
                if (accept != '0) begin
                    start     = 1'b1;
                    state_nxt = (accept == mask_live) ? FULL : COLLECT;
                end
            end
            COLLECT: begin
                ready_c  = mask_q & ~filled;
                accept   = bus.pe_valid & ready_c;
                complete = ((filled | accept) & mask_q) == mask_q;
                if (complete || timeout_hit) state_nxt = FULL;
            end
            FULL: begin
                transfer = !out_valid_q || bus.out_ready;
                if (transfer) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held low during reset so the live-cfg mask never leaks out of IDLE.
    assign bus.pe_ready = rst_n ? ready_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled      <= '0;
            vec         <= '0;
            shift_q     <= '0;
            group_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_shift_q <= '0;
            out_group_q <= '0;
        end else begin
            if (start) begin
                shift_q <= bus.cfg_shift;
                group_q <= bus.cfg_group_size;
            end
            for (int i = 0; i < NOF_PES; i++) begin
                if (accept[i])
                    vec[i*WORD_SIZE +: WORD_SIZE] <= bus.pe_data[i*WORD_SIZE +: WORD_SIZE];
                else if (start)
                    vec[i*WORD_SIZE +: WORD_SIZE] <= '0;
            end
            filled <= transfer ? '0 : (filled | accept);
            if (transfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= vec;
                out_shift_q <= shift_q;
                out_group_q <= group_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_shift      = out_shift_q;
    assign bus.out_group_size = out_group_q;

`ifdef BSF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             partial_q;
    logic             out_partial_q;

    // Fires on the edge where the counter would reach TIMEOUT_CYCLES.
    assign timeout_hit = (state == COLLECT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            partial_q     <= 1'b0;
            out_partial_q <= 1'b0;
        end else begin
            if (start)
                cnt <= '0;
            else if (state == COLLECT && cnt != CNT_W'(TIMEOUT_CYCLES))
                cnt <= cnt + CNT_W'(1);
            if (start)
                partial_q <= 1'b0;
            else if (timeout_hit && !complete)
                partial_q <= 1'b1;
            if (transfer)
                out_partial_q <= partial_q;
        end
    end

    assign bus.out_partial = out_partial_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.out_partial = 1'b0;
`endif

endmodule
